// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and decode-side handshake bundle for instr_decode_stage.
//   flush                        : synchronous discard of all buffered instructions
//   in_valid/in_ready/in_instr/in_pc : fetch -> decode handshake
//   out_valid/out_ready          : decode -> downstream handshake
//   out_opcode..out_target       : bit fields of the head instruction
//   out_fmt                      : 0=R, 1=I, 2=J
//   out_pc                       : PC of the head instruction
//   out_count                    : delivered-instruction counter
// master drives the stage (fetch and downstream together); slave is the stage itself.
interface instr_decode_stage_if #(parameter int PC_W = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_opcode;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_rd;
   logic [4:0]      out_shamt;
   logic [5:0]      out_funct;
   logic [15:0]     out_imm16;
   logic [25:0]     out_target;
   logic [1:0]      out_fmt;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_count;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm16, out_target, out_fmt, out_pc, out_count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm16, out_target, out_fmt, out_pc, out_count
   );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: 2-entry skid buffer for fetched instructions plus field/format decode of the head.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : instr_decode_stage_if.slave (handshakes, decoded fields, out_pc, out_count)
// Optional: define DECODE_STATS_EN to count delivered instructions on out_count;
// otherwise out_count is tied to zero.
module instr_decode_stage #(
   parameter int PC_W = 32
) (
   input logic                 clk,
   input logic                 rst,
   instr_decode_stage_if.slave bus
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [31:0]     head_instr, head_instr_nxt, tail_instr, tail_instr_nxt;
   logic [PC_W-1:0] head_pc, head_pc_nxt, tail_pc, tail_pc_nxt;
   logic            push, pop;

   // in_ready depends only on the registered state, never on out_ready
   assign bus.in_ready  = state != FULL;
   assign bus.out_valid = state != EMPTY;
   // an instruction offered during flush is dropped even when in_ready is high
   assign push = bus.in_valid && bus.in_ready && !bus.flush;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         head_instr <= '0;
         head_pc    <= '0;
         tail_instr <= '0;
         tail_pc    <= '0;
      end else begin
         state      <= state_nxt;
         head_instr <= head_instr_nxt;
         head_pc    <= head_pc_nxt;
         tail_instr <= tail_instr_nxt;
         tail_pc    <= tail_pc_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      head_instr_nxt = head_instr;
      head_pc_nxt    = head_pc;
      tail_instr_nxt = tail_instr;
      tail_pc_nxt    = tail_pc;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt      = ONE;
               head_instr_nxt = bus.in_instr;
               head_pc_nxt    = bus.in_pc;
            end
         end
         ONE: begin
            if (push && pop) begin
               // pass-through: the new entry replaces the departing head, no bubble
               head_instr_nxt = bus.in_instr;
               head_pc_nxt    = bus.in_pc;
            end else if (push) begin
               state_nxt      = FULL;
               tail_instr_nxt = bus.in_instr;
               tail_pc_nxt    = bus.in_pc;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt      = ONE;
               head_instr_nxt = tail_instr;
               head_pc_nxt    = tail_pc;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (bus.flush) state_nxt = EMPTY;
   end

   assign bus.out_opcode = head_instr[31:26];
   assign bus.out_rs     = head_instr[25:21];
   assign bus.out_rt     = head_instr[20:16];
   assign bus.out_rd     = head_instr[15:11];
   assign bus.out_shamt  = head_instr[10:6];
   assign bus.out_funct  = head_instr[5:0];
   assign bus.out_imm16  = head_instr[15:0];
   assign bus.out_target = head_instr[25:0];
   assign bus.out_pc     = head_pc;
   assign bus.out_fmt    = (head_instr[31:26] == 6'h00) ? 2'd0 :
                           (head_instr[31:26] == 6'h02 || head_instr[31:26] == 6'h03) ? 2'd2 : 2'd1;

`ifdef DECODE_STATS_EN
   logic [31:0] count;

   // counts every deliver, including one in a flush cycle; wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else     count <= count + 32'(pop);
   end

   assign bus.out_count = count;
`else
   assign bus.out_count = 32'h0;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed table-driven bench for instr_decode_stage.
module tb_instr_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   instr_decode_stage_if #(.PC_W(32)) bus ();
   instr_decode_stage #(.PC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ordy;
      logic        ov;
      logic        ir;
      logic [31:0] hi;
      logic [31:0] hpc;
      logic [1:0]  fmt;
      int          cnt;
   } vec_t;

   vec_t v[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_cnt(input int c);
`ifdef DECODE_STATS_EN
      return c;
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] instr,
                        input logic [31:0] pc, input logic ordy);
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.in_instr  = instr;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] hi, input logic [31:0] hpc,
                           input logic [1:0] fmt);
      chk({tag, " opcode"}, 32'(bus.out_opcode), 32'(hi[31:26]));
      chk({tag, " rs"},     32'(bus.out_rs),     32'(hi[25:21]));
      chk({tag, " rt"},     32'(bus.out_rt),     32'(hi[20:16]));
      chk({tag, " rd"},     32'(bus.out_rd),     32'(hi[15:11]));
      chk({tag, " shamt"},  32'(bus.out_shamt),  32'(hi[10:6]));
      chk({tag, " funct"},  32'(bus.out_funct),  32'(hi[5:0]));
      chk({tag, " imm16"},  32'(bus.out_imm16),  32'(hi[15:0]));
      chk({tag, " target"}, 32'(bus.out_target), 32'(hi[25:0]));
      chk({tag, " fmt"},    32'(bus.out_fmt),    32'(fmt));
      chk({tag, " pc"},     bus.out_pc,          hpc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
      chk({tag, " in_ready"},  32'(bus.in_ready),  32'h1);
      chk_head(tag, 32'h0, 32'h0, 2'd0);
      chk({tag, " count"}, bus.out_count, 32'h0);
   endtask

   initial begin
      //     fl    iv    instr         pc         ordy  ov    ir    head          hpc        fmt   cnt
      v[0]  = '{1'b0, 1'b1, 32'h8D2A0004, 32'h100, 1'b1, 1'b1, 1'b1, 32'h8D2A0004, 32'h100, 2'd1, 0};
      v[1]  = '{1'b0, 1'b1, 32'h012A4020, 32'h104, 1'b1, 1'b1, 1'b1, 32'h012A4020, 32'h104, 2'd0, 1};
      v[2]  = '{1'b0, 1'b1, 32'h08000040, 32'h108, 1'b1, 1'b1, 1'b1, 32'h08000040, 32'h108, 2'd2, 2};
      v[3]  = '{1'b0, 1'b1, 32'h2129FFFF, 32'h10C, 1'b1, 1'b1, 1'b1, 32'h2129FFFF, 32'h10C, 2'd1, 3};
      v[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 4};
      v[5]  = '{1'b0, 1'b1, 32'h3C01ABCD, 32'h200, 1'b0, 1'b1, 1'b1, 32'h3C01ABCD, 32'h200, 2'd1, 4};
      v[6]  = '{1'b0, 1'b1, 32'h00851020, 32'h204, 1'b0, 1'b1, 1'b0, 32'h3C01ABCD, 32'h200, 2'd1, 4};
      v[7]  = '{1'b0, 1'b1, 32'h0C000100, 32'h208, 1'b0, 1'b1, 1'b0, 32'h3C01ABCD, 32'h200, 2'd1, 4};
      v[8]  = '{1'b0, 1'b1, 32'h0C000100, 32'h208, 1'b0, 1'b1, 1'b0, 32'h3C01ABCD, 32'h200, 2'd1, 4};
      v[9]  = '{1'b0, 1'b1, 32'h0C000100, 32'h208, 1'b1, 1'b1, 1'b1, 32'h00851020, 32'h204, 2'd0, 5};
      v[10] = '{1'b0, 1'b1, 32'h0C000100, 32'h208, 1'b1, 1'b1, 1'b1, 32'h0C000100, 32'h208, 2'd2, 6};
      v[11] = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 7};
      v[12] = '{1'b0, 1'b1, 32'h8D2A0004, 32'h300, 1'b0, 1'b1, 1'b1, 32'h8D2A0004, 32'h300, 2'd1, 7};
      v[13] = '{1'b0, 1'b1, 32'h2129FFFF, 32'h304, 1'b0, 1'b1, 1'b0, 32'h8D2A0004, 32'h300, 2'd1, 7};
      v[14] = '{1'b1, 1'b1, 32'h012A4020, 32'h308, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 7};
      v[15] = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 7};
      v[16] = '{1'b0, 1'b1, 32'h08000040, 32'h30C, 1'b0, 1'b1, 1'b1, 32'h08000040, 32'h30C, 2'd2, 7};
      v[17] = '{1'b1, 1'b1, 32'h3C01ABCD, 32'h310, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 8};
      v[18] = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   2'd0, 8};

      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #12;
      chk_reset_outputs("in_reset");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_reset_outputs("idle");

      for (int i = 0; i < 19; i++) begin
         drive(v[i].fl, v[i].iv, v[i].instr, v[i].pc, v[i].ordy);
         tick();
         chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(v[i].ov));
         chk($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(v[i].ir));
         chk($sformatf("v%0d count", i),     bus.out_count,      32'(exp_cnt(v[i].cnt)));
         if (v[i].ov) chk_head($sformatf("v%0d", i), v[i].hi, v[i].hpc, v[i].fmt);
         if (i == 0) begin
            chk("lw opcode", 32'(bus.out_opcode), 32'h23);
            chk("lw rs",     32'(bus.out_rs),     32'd9);
            chk("lw rt",     32'(bus.out_rt),     32'd10);
            chk("lw imm16",  32'(bus.out_imm16),  32'h0004);
         end
         if (i == 1) begin
            chk("add rd",    32'(bus.out_rd),    32'd8);
            chk("add funct", 32'(bus.out_funct), 32'h20);
         end
         if (i == 2) chk("j target", 32'(bus.out_target), 32'h0000040);
         if (i == 3) chk("addi imm16", 32'(bus.out_imm16), 32'hFFFF);
      end

      // asynchronous reset with a full buffer discards everything immediately
      drive(1'b0, 1'b1, 32'h8D2A0004, 32'h400, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'h012A4020, 32'h404, 1'b0);
      tick();
      chk("pre_reset in_ready", 32'(bus.in_ready), 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_reset out_valid", 32'(bus.out_valid), 32'h0);

      drive(1'b0, 1'b1, 32'h2129FFFF, 32'h500, 1'b1);
      tick();
      chk_head("post_reset", 32'h2129FFFF, 32'h500, 2'd1);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      chk("post_reset drained", 32'(bus.out_valid), 32'h0);
      chk("post_reset count", bus.out_count, 32'(exp_cnt(1)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Decode stage that sits directly upstream of sign_extender in the single-issue MIPS-style datapath.
- Buffers fetched 32-bit instructions in a 2-entry skid buffer with a valid/ready handshake on both sides.
- Splits the head instruction into register, function, immediate and jump fields and classifies its format.
- out_imm16 drives sign_extender.immediate_in directly.

Parameters:
- PC_W, 32, width of the program-counter tag carried alongside each instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_funct  output  6  instr[5:0].
- out_imm16  output  16  instr[15:0], to sign_extender.
- out_target  output  26  instr[25:0].
- out_fmt  output  2  format: 0=R, 1=I, 2=J; 3 is never driven.
- out_pc  output  PC_W  PC of the head entry.
- out_count  output  32  delivered-instruction counter (see Optional Feature).

Behaviour:
- Storage: two entries (instr, pc), FIFO order. Occupancy state is EMPTY, ONE or FULL.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- in_ready = (state != FULL). It is a registered function of state and does not depend combinationally on out_ready.
- out_valid = (state != EMPTY).
- Output fields are combinationally decoded from the head entry. They are stable while out_valid=1 and out_ready=0.
- Latency: an instruction accepted at edge N is visible at the output after edge N (one cycle) when the buffer was EMPTY. Otherwise it is visible after all older entries have been delivered.
- State transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept and no deliver -> FULL; deliver and no accept -> EMPTY; accept and deliver together -> ONE, with the new entry becoming head.
  - FULL: deliver -> ONE, with the second entry promoted to head. No accept is possible.
- Simultaneous accept and deliver in ONE: occupancy is unchanged, throughput is 1 instruction per cycle, and no bubble is inserted.
- out_fmt decoding:
  - opcode == 6'h00 -> R (0).
  - opcode == 6'h02 or 6'h03 -> J (2).
  - Any other opcode -> I (1). No illegal-opcode detection.
- Field extraction is pure bit slicing: no sign or zero extension in this block.
- flush:
  - Next state is EMPTY, regardless of in_valid or out_ready that cycle.
  - An instruction presented with flush=1 is dropped, even if in_ready=1.
  - A deliver handshake in the flush cycle still counts as delivered.
- rst (asynchronous):
  - state=EMPTY, both entries cleared to 0, out_count=0.
  - All decoded outputs are therefore 0 during and after reset, with out_fmt=0, out_valid=0 and in_ready=1.
  - Reset mid-transfer loses all buffered instructions.
- An entry is never overwritten while valid. Overflow and underflow are impossible by construction.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined: out_count increments by 1 on every deliver handshake (including in the flush cycle) and wraps 32'hFFFFFFFF -> 0. It resets to 0 and is not cleared by flush.
- Undefined: out_count is tied to 32'h0, and no counter logic is synthesized.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, all fields 0; after releasing rst, state stays EMPTY.
- Push 0x8D2A0004 (lw $t2,4($t1)), pc 0x100, out_ready=1 -> next cycle out_opcode=0x23, out_rs=9, out_rt=10, out_imm16=0x0004, out_fmt=1, out_pc=0x100.
- Stream 0x012A4020 (add), 0x08000040 (j), 0x2129FFFF (addi -1) back-to-back with out_ready=1:
  - add -> out_fmt=0, out_rd=8, out_funct=0x20.
  - j -> out_fmt=2, out_target=0x0000040.
  - addi -> out_imm16=0xFFFF.
  - One instruction delivered per cycle.
- Hold out_ready=0 and push 3 instructions -> in_ready drops after 2 accepts and the third is held by fetch. Raise out_ready -> instructions delivered in order with no loss or duplication.
- With FULL, assert flush and in_valid together -> next cycle out_valid=0, in_ready=1, and the presented instruction never appears at the output.
- With DECODE_STATS_EN defined, deliver 5 instructions -> out_count=5. With the macro undefined -> out_count=0 throughout.
